// File: rtl/idu_pkg.sv
// -----------------------------------------------------------------------------
// idu_pkg
//   Shared definitions for the IDU instruction queue:
//     - default DEPTH / FETCH_W / DISPATCH_W constants
//     - popcount()      : number of set bits in a lane mask
//     - leading_ones()  : length of the unbroken run of ones starting at bit 0
//   Both helpers take a VEC_MAX-bit vector; callers zero-extend their narrower
//   lane masks, so the zero padding never contributes to either result.
// -----------------------------------------------------------------------------
package idu_pkg;

  localparam int unsigned INSTQ_DEPTH_DEF = 8;
  localparam int unsigned FETCH_W_DEF     = 2;
  localparam int unsigned DISPATCH_W_DEF  = 2;

  // Widest lane mask the helpers accept.
  localparam int unsigned VEC_MAX = 32;

  function automatic int unsigned popcount(input logic [VEC_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < VEC_MAX; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

  // Counts consecutive ones from bit 0; everything after the first zero is
  // ignored, so 2'b10 yields 0 and 2'b11 yields 2.
  function automatic int unsigned leading_ones(input logic [VEC_MAX-1:0] v);
    int unsigned n;
    logic        run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < VEC_MAX; i++) begin
      run = run & v[i];
      n   = n + 32'(run);
    end
    return n;
  endfunction

endpackage

// File: rtl/u_idu_instq_compact.sv
// -----------------------------------------------------------------------------
// u_idu_instq_compact
//   Purely combinational fetch-lane compactor. Each set lane of lane_vld is
//   given a write offset equal to the number of set lanes below it, so the
//   k-th valid instruction lands at wr_ptr+k with no holes in the queue.
//
// Ports
//   lane_vld  in   FETCH_W            per-lane fetch-valid mask (any pattern)
//   lane_en   out  FETCH_W            lane i is written this cycle
//   lane_off  out  FETCH_W x OFF_W    write offset of lane i from wr_ptr
//   push_cnt  out  CNT_W              number of lanes written (popcount)
// -----------------------------------------------------------------------------
module u_idu_instq_compact
  import idu_pkg::*;
#(
  parameter int unsigned FETCH_W = FETCH_W_DEF,
  parameter int unsigned OFF_W   = (FETCH_W > 1) ? $clog2(FETCH_W) : 1,
  parameter int unsigned CNT_W   = $clog2(FETCH_W + 1)
) (
  input  logic [FETCH_W-1:0]            lane_vld,
  output logic [FETCH_W-1:0]            lane_en,
  output logic [FETCH_W-1:0][OFF_W-1:0] lane_off,
  output logic [CNT_W-1:0]              push_cnt
);

  logic [CNT_W-1:0] run;

  assign lane_en  = lane_vld;
  assign push_cnt = CNT_W'(popcount(VEC_MAX'(lane_vld)));

  // NOTE: 'run' is a running sum inside one combinational pass, so it must use
  // blocking assignments and be given a value before the loop reads it.
  always_comb begin
    run      = '0;
    lane_off = '0;
    for (int j = 0; j < FETCH_W; j++) begin
      // Only meaningful for set lanes, where run <= FETCH_W-1 fits in OFF_W.
      lane_off[j] = OFF_W'(run);
      run         = run + CNT_W'(lane_vld[j]);
    end
  end

endmodule

// File: rtl/u_idu_instqueue.sv
// -----------------------------------------------------------------------------
// u_idu_instqueue
//   Circular instruction FIFO between the IFU fetch pipe and the IDU
//   dispatcher. Valid fetch lanes are compacted on write, the dispatcher
//   consumes an in-order prefix of the head lanes, and the whole queue is
//   emptied on a BRU redirect or an exception/WFI seen by the dispatcher.
//
// Parameters
//   DEPTH       entry count, power of two, >= max(FETCH_W, DISPATCH_W), >= 2
//   FETCH_W     instructions offered per fetch cycle
//   DISPATCH_W  instructions presented to the dispatcher per cycle
//   INST_W      instruction width (default `INST_WIDTH)
//   PC_W        PC width          (default `PC_WIDTH)
//
// Ports
//   clk, rst_n                        clock, synchronous active-low reset
//   ifu_idu_fetch_vld                 fetch group valid
//   fetch_lane_vld  [FETCH_W]         per-lane valid mask
//   inst_in/pc_in/unalign_pc_in       fetch lanes, lane 0 oldest
//   idu_ifu_instq_full                free entries < FETCH_W
//   instq_occupancy                   valid entry count
//   dispatch_vld    [DISPATCH_W]      dispatcher consumes head lane i
//   bru_flush                         branch redirect flush
//   dispatcher_detect_exceptions_wfi  exception/WFI flush
//   inst_vld/inst_out/pc_out/unalign_pc_out  head lanes, lane 0 oldest;
//                                     data is zero on invalid lanes
//   instq_stall_cnt [32]              only with INSTQ_PERF_CNT_EN: saturating
//                                     count of cycles fetch was held off by full
//
// Build option
//   INSTQ_PERF_CNT_EN  adds the stall counter and its output port.
// -----------------------------------------------------------------------------
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module u_idu_instqueue
  import idu_pkg::*;
#(
  parameter int unsigned DEPTH      = INSTQ_DEPTH_DEF,
  parameter int unsigned FETCH_W    = FETCH_W_DEF,
  parameter int unsigned DISPATCH_W = DISPATCH_W_DEF,
  parameter int unsigned INST_W     = `INST_WIDTH,
  parameter int unsigned PC_W       = `PC_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  // fetch side
  input  logic                                 ifu_idu_fetch_vld,
  input  logic [FETCH_W-1:0]                   fetch_lane_vld,
  input  logic [FETCH_W-1:0][INST_W-1:0]       inst_in,
  input  logic [FETCH_W-1:0][PC_W-1:0]         pc_in,
  input  logic [FETCH_W-1:0]                   unalign_pc_in,
  output logic                                 idu_ifu_instq_full,
  output logic [$clog2(DEPTH+1)-1:0]           instq_occupancy,
  // dispatch side
  input  logic [DISPATCH_W-1:0]                dispatch_vld,
  input  logic                                 bru_flush,
  input  logic                                 dispatcher_detect_exceptions_wfi,
`ifdef INSTQ_PERF_CNT_EN
  output logic [31:0]                          instq_stall_cnt,
`endif
  output logic [DISPATCH_W-1:0]                inst_vld,
  output logic [DISPATCH_W-1:0][INST_W-1:0]    inst_out,
  output logic [DISPATCH_W-1:0][PC_W-1:0]      pc_out,
  output logic [DISPATCH_W-1:0]                unalign_pc_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned FC_W  = $clog2(FETCH_W + 1);
  localparam int unsigned DC_W  = $clog2(DISPATCH_W + 1);
  localparam int unsigned OFF_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic              unalign;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  entry_t           mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  logic                            flush;
  logic                            do_push;
  logic [CNT_W-1:0]                free_cnt;
  logic [FETCH_W-1:0]              lane_en;
  logic [FETCH_W-1:0][OFF_W-1:0]   lane_off;
  logic [FC_W-1:0]                 push_cnt;
  logic [FC_W-1:0]                 push_acc;
  logic [DC_W-1:0]                 pop_cnt;

  assign flush    = bru_flush | dispatcher_detect_exceptions_wfi;

  // Full looks at the current count only; room freed by a same-cycle pop is
  // not credited until the next cycle, which keeps full off the dispatch path.
  assign free_cnt           = CNT_W'(DEPTH) - count;
  assign idu_ifu_instq_full = free_cnt < CNT_W'(FETCH_W);
  assign instq_occupancy    = count;

  // A group offered while full is dropped; the IFU holds and re-offers it.
  assign do_push  = ifu_idu_fetch_vld & ~idu_ifu_instq_full & ~flush;
  assign push_acc = do_push ? push_cnt : '0;

  // Only an unbroken prefix of consumed valid lanes leaves the queue.
  assign pop_cnt  = DC_W'(leading_ones(VEC_MAX'(dispatch_vld & inst_vld)));

  u_idu_instq_compact #(
    .FETCH_W (FETCH_W),
    .OFF_W   (OFF_W),
    .CNT_W   (FC_W)
  ) u_compact (
    .lane_vld (fetch_lane_vld),
    .lane_en  (lane_en),
    .lane_off (lane_off),
    .push_cnt (push_cnt)
  );

  // ---------------------------------------------------------------------------
  // Pointers and count. Reset and flush are the same action: an empty queue
  // with both pointers at entry 0; any push or pop that cycle is discarded.
  // ---------------------------------------------------------------------------
  // NOTE: rst_n is tested inside the clocked block only, making it a
  // synchronous reset; it is deliberately absent from the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH.
      rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
      wr_ptr <= wr_ptr + PTR_W'(push_acc);
      count  <= count + CNT_W'(push_acc) - CNT_W'(pop_cnt);
    end
  end

  // ---------------------------------------------------------------------------
  // Storage write: compacted lanes land at consecutive entries from wr_ptr.
  // ---------------------------------------------------------------------------
  // NOTE: the entry array has no reset; entries are only observable once
  // count covers them, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    for (int j = 0; j < FETCH_W; j++) begin
      if (do_push && lane_en[j]) begin
        mem[wr_ptr + PTR_W'(lane_off[j])] <= '{
          inst:    inst_in[j],
          pc:      pc_in[j],
          unalign: unalign_pc_in[j]
        };
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Head lanes: lane i shows entry rd_ptr+i while count > i, zeros otherwise,
  // so stale storage never reaches the dispatcher.
  // ---------------------------------------------------------------------------
  always_comb begin
    inst_vld       = '0;
    inst_out       = '0;
    pc_out         = '0;
    unalign_pc_out = '0;
    for (int i = 0; i < DISPATCH_W; i++) begin
      if (count > CNT_W'(i)) begin
        inst_vld[i]       = 1'b1;
        inst_out[i]       = mem[rd_ptr + PTR_W'(i)].inst;
        pc_out[i]         = mem[rd_ptr + PTR_W'(i)].pc;
        unalign_pc_out[i] = mem[rd_ptr + PTR_W'(i)].unalign;
      end
    end
  end

`ifdef INSTQ_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Stall counter: cycles in which fetch offered a group but the queue was
  // full. Survives flushes so it spans a whole run; saturates at all-ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instq_stall_cnt <= '0;
    end else if (ifu_idu_fetch_vld && idu_ifu_instq_full &&
                 (instq_stall_cnt != '1)) begin
      instq_stall_cnt <= instq_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_u_idu_instqueue.sv
// -----------------------------------------------------------------------------
// tb_u_idu_instqueue
//   Directed bench for u_idu_instqueue with DEPTH=8, FETCH_W=DISPATCH_W=2.
//   A table of single-cycle vectors walks reset, fill-to-full, drop-on-full,
//   partial dispatch, sparse fetch masks and both flush sources. Hand-written
//   sequences then stream push-2/pop-2 across the pointer wrap against a queue
//   model and exercise the stall counter when INSTQ_PERF_CNT_EN is defined.
//   Lane data is an 8-bit tag d: inst = d, pc = 0x8000_00dd, unalign = d[0].
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_u_idu_instqueue;

  localparam int DEPTH = 8;
  localparam int FW    = 2;
  localparam int DW    = 2;
  localparam int IW    = 32;
  localparam int PW    = 32;

  logic                    clk;
  logic                    rst_n;
  logic                    ifu_idu_fetch_vld;
  logic [FW-1:0]           fetch_lane_vld;
  logic [FW-1:0][IW-1:0]   inst_in;
  logic [FW-1:0][PW-1:0]   pc_in;
  logic [FW-1:0]           unalign_pc_in;
  logic                    idu_ifu_instq_full;
  logic [3:0]              instq_occupancy;
  logic [DW-1:0]           dispatch_vld;
  logic                    bru_flush;
  logic                    dispatcher_detect_exceptions_wfi;
  logic [DW-1:0]           inst_vld;
  logic [DW-1:0][IW-1:0]   inst_out;
  logic [DW-1:0][PW-1:0]   pc_out;
  logic [DW-1:0]           unalign_pc_out;
`ifdef INSTQ_PERF_CNT_EN
  logic [31:0]             instq_stall_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;

  u_idu_instqueue #(
    .DEPTH      (DEPTH),
    .FETCH_W    (FW),
    .DISPATCH_W (DW),
    .INST_W     (IW),
    .PC_W       (PW)
  ) dut (
    .clk                              (clk),
    .rst_n                            (rst_n),
    .ifu_idu_fetch_vld                (ifu_idu_fetch_vld),
    .fetch_lane_vld                   (fetch_lane_vld),
    .inst_in                          (inst_in),
    .pc_in                            (pc_in),
    .unalign_pc_in                    (unalign_pc_in),
    .idu_ifu_instq_full               (idu_ifu_instq_full),
    .instq_occupancy                  (instq_occupancy),
    .dispatch_vld                     (dispatch_vld),
    .bru_flush                        (bru_flush),
    .dispatcher_detect_exceptions_wfi (dispatcher_detect_exceptions_wfi),
`ifdef INSTQ_PERF_CNT_EN
    .instq_stall_cnt                  (instq_stall_cnt),
`endif
    .inst_vld                         (inst_vld),
    .inst_out                         (inst_out),
    .pc_out                           (pc_out),
    .unalign_pc_out                   (unalign_pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       fv;
    logic [1:0] mask;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] disp;
    logic       bru;
    logic       exc;
    int         occ;
    logic       full;
    logic [1:0] vld;
    logic [7:0] o0;
    logic [7:0] o1;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pc_of(input logic [7:0] d);
    return {24'h800000, d};
  endfunction

  task automatic drive(input logic r, input logic fv, input logic [1:0] mask,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [1:0] disp, input logic bru, input logic exc);
    rst_n                            = r;
    ifu_idu_fetch_vld                = fv;
    fetch_lane_vld                   = mask;
    inst_in[0]                       = 32'(d0);
    inst_in[1]                       = 32'(d1);
    pc_in[0]                         = pc_of(d0);
    pc_in[1]                         = pc_of(d1);
    unalign_pc_in                    = {d1[0], d0[0]};
    dispatch_vld                     = disp;
    bru_flush                        = bru;
    dispatcher_detect_exceptions_wfi = exc;
  endtask

  // Head lane comparison derived from an expected tag and valid bit.
  task automatic check_lane(input string tag, input int i, input logic v,
                            input logic [7:0] d);
    check($sformatf("%s inst%0d", tag, i), 64'(inst_out[i]), v ? 64'(d) : 64'd0);
    check($sformatf("%s pc%0d", tag, i), 64'(pc_out[i]), v ? 64'(pc_of(d)) : 64'd0);
    check($sformatf("%s ua%0d", tag, i), 64'(unalign_pc_out[i]), v ? 64'(d[0]) : 64'd0);
  endtask

  initial begin
    int q[$];
    int seq;
    int pre;
    int npop;
    logic acc;

    //             rst fv mask   d0     d1    disp  bru exc  occ full vld    o0     o1
    vecs[0]  = '{1'b0,1'b1,2'b11,8'h55,8'h66,2'b11,1'b0,1'b0, 0,1'b0,2'b00,8'h00,8'h00};
    vecs[1]  = '{1'b0,1'b1,2'b11,8'h77,8'h88,2'b00,1'b1,1'b0, 0,1'b0,2'b00,8'h00,8'h00};
    vecs[2]  = '{1'b1,1'b1,2'b11,8'h00,8'h01,2'b00,1'b0,1'b0, 2,1'b0,2'b11,8'h00,8'h01};
    vecs[3]  = '{1'b1,1'b1,2'b11,8'h02,8'h03,2'b00,1'b0,1'b0, 4,1'b0,2'b11,8'h00,8'h01};
    vecs[4]  = '{1'b1,1'b1,2'b11,8'h04,8'h05,2'b00,1'b0,1'b0, 6,1'b0,2'b11,8'h00,8'h01};
    vecs[5]  = '{1'b1,1'b1,2'b11,8'h06,8'h07,2'b00,1'b0,1'b0, 8,1'b1,2'b11,8'h00,8'h01};
    vecs[6]  = '{1'b1,1'b1,2'b11,8'h08,8'h09,2'b00,1'b0,1'b0, 8,1'b1,2'b11,8'h00,8'h01};
    vecs[7]  = '{1'b1,1'b0,2'b00,8'h00,8'h00,2'b01,1'b0,1'b0, 7,1'b1,2'b11,8'h01,8'h02};
    vecs[8]  = '{1'b1,1'b0,2'b00,8'h00,8'h00,2'b11,1'b0,1'b0, 5,1'b0,2'b11,8'h03,8'h04};
    vecs[9]  = '{1'b1,1'b0,2'b00,8'h00,8'h00,2'b11,1'b0,1'b0, 3,1'b0,2'b11,8'h05,8'h06};
    vecs[10] = '{1'b1,1'b0,2'b00,8'h00,8'h00,2'b11,1'b0,1'b0, 1,1'b0,2'b01,8'h07,8'h00};
    vecs[11] = '{1'b1,1'b0,2'b00,8'h00,8'h00,2'b01,1'b0,1'b0, 0,1'b0,2'b00,8'h00,8'h00};
    vecs[12] = '{1'b1,1'b1,2'b10,8'h33,8'hA5,2'b00,1'b0,1'b0, 1,1'b0,2'b01,8'hA5,8'h00};
    vecs[13] = '{1'b1,1'b0,2'b00,8'h00,8'h00,2'b10,1'b0,1'b0, 1,1'b0,2'b01,8'hA5,8'h00};
    vecs[14] = '{1'b1,1'b1,2'b11,8'h10,8'h11,2'b01,1'b0,1'b0, 2,1'b0,2'b11,8'h10,8'h11};
    vecs[15] = '{1'b1,1'b1,2'b11,8'h20,8'h21,2'b11,1'b1,1'b0, 0,1'b0,2'b00,8'h00,8'h00};
    vecs[16] = '{1'b1,1'b1,2'b11,8'h22,8'h23,2'b00,1'b0,1'b0, 2,1'b0,2'b11,8'h22,8'h23};
    vecs[17] = '{1'b1,1'b1,2'b11,8'h24,8'h25,2'b01,1'b0,1'b1, 0,1'b0,2'b00,8'h00,8'h00};
    vecs[18] = '{1'b1,1'b1,2'b01,8'h41,8'h42,2'b00,1'b0,1'b0, 1,1'b0,2'b01,8'h41,8'h00};
    vecs[19] = '{1'b1,1'b1,2'b00,8'h50,8'h51,2'b00,1'b0,1'b0, 1,1'b0,2'b01,8'h41,8'h00};
    vecs[20] = '{1'b1,1'b0,2'b11,8'h60,8'h61,2'b00,1'b0,1'b0, 1,1'b0,2'b01,8'h41,8'h00};
    vecs[21] = '{1'b0,1'b1,2'b11,8'h70,8'h71,2'b01,1'b0,1'b0, 0,1'b0,2'b00,8'h00,8'h00};

    drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);

    // ---------------- table-driven single-cycle vectors ----------------
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      drive(vecs[k].rst_n, vecs[k].fv, vecs[k].mask, vecs[k].d0, vecs[k].d1,
            vecs[k].disp, vecs[k].bru, vecs[k].exc);
      @(posedge clk);
      #1;
      check($sformatf("v%0d occ", k), 64'(instq_occupancy), 64'(vecs[k].occ));
      check($sformatf("v%0d full", k), 64'(idu_ifu_instq_full), 64'(vecs[k].full));
      check($sformatf("v%0d vld", k), 64'(inst_vld), 64'(vecs[k].vld));
      check_lane($sformatf("v%0d", k), 0, vecs[k].vld[0], vecs[k].o0);
      check_lane($sformatf("v%0d", k), 1, vecs[k].vld[1], vecs[k].o1);
    end

    // ---------------- streaming push 2 / pop 2 across the wrap ----------------
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    q   = {};
    seq = 8'h80;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 2'b11, 8'(seq), 8'(seq + 1), 2'b11, 1'b0, 1'b0);
      pre  = q.size();
      npop = (pre >= 2) ? 2 : pre;
      acc  = (DEPTH - pre) >= FW;
      @(posedge clk);
      #1;
      for (int p = 0; p < npop; p++) void'(q.pop_front());
      if (acc) begin
        q.push_back(seq);
        q.push_back(seq + 1);
        seq = seq + 2;
      end
      check($sformatf("s%0d occ", c), 64'(instq_occupancy), 64'(q.size()));
      for (int i = 0; i < DW; i++) begin
        check($sformatf("s%0d pc%0d", c, i), 64'(pc_out[i]),
              (q.size() > i) ? 64'(pc_of(8'(q[i]))) : 64'd0);
      end
    end

    // ---------------- fill to full, then stall ----------------
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("prst occ", 64'(instq_occupancy), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 2'b11, 8'(2 * k), 8'(2 * k + 1), 2'b00, 1'b0, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 2'b11, 8'hEE, 8'hEF, 2'b00, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("stall%0d full", k), 64'(idu_ifu_instq_full), 64'd1);
      check($sformatf("stall%0d occ", k), 64'(instq_occupancy), 64'd8);
      check_lane($sformatf("stall%0d", k), 0, 1'b1, 8'h00);
    end
`ifdef INSTQ_PERF_CNT_EN
    check("stall cnt", 64'(instq_stall_cnt), 64'd3);
`endif
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("pflush occ", 64'(instq_occupancy), 64'd0);
    check("pflush full", 64'(idu_ifu_instq_full), 64'd0);
`ifdef INSTQ_PERF_CNT_EN
    check("stall cnt kept", 64'(instq_stall_cnt), 64'd3);
`endif

    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/u_idu_instqueue.md
# u_idu_instqueue

Parametrised successor to the IDU instruction buffer. A circular FIFO between the IFU fetch pipe and the IDU dispatcher, with configurable depth, fetch width and dispatch width. Adds per-lane fetch-valid compaction, in-order partial dispatch and an occupancy output. Flushes on BRU redirect or on a dispatcher-detected exception/WFI.

## Interface
Parameters:
- DEPTH, 8, entry count; power of two, ≥ max(FETCH_W, DISPATCH_W)
- FETCH_W, 2, instructions offered per fetch cycle
- DISPATCH_W, 2, instructions presented to the dispatcher per cycle
- INST_W, `INST_WIDTH, instruction width
- PC_W, `PC_WIDTH, PC width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ifu_idu_fetch_vld  in  1  fetch group valid
- fetch_lane_vld  in  FETCH_W  per-lane valid mask; any pattern legal
- inst_in  in  FETCH_W×INST_W  lane instructions; lane 0 is oldest
- pc_in  in  FETCH_W×PC_W  lane PCs
- unalign_pc_in  in  FETCH_W  lane misaligned-PC flags
- idu_ifu_instq_full  out  1  asserted when free entries < FETCH_W
- instq_occupancy  out  $clog2(DEPTH+1)  valid entry count
- dispatch_vld  in  DISPATCH_W  dispatcher consumes lane i
- bru_flush  in  1  branch redirect flush
- dispatcher_detect_exceptions_wfi  in  1  exception/WFI flush
- inst_vld  out  DISPATCH_W  head lane i valid
- inst_out  out  DISPATCH_W×INST_W  head instructions; lane 0 is oldest
- pc_out  out  DISPATCH_W×PC_W  head PCs
- unalign_pc_out  out  DISPATCH_W  head misaligned-PC flags

## Operation
- State: rd_ptr and wr_ptr, log2(DEPTH) bits each, wrapping naturally modulo DEPTH; count, $clog2(DEPTH+1) bits. Storage array is not reset.
- Push condition: ifu_idu_fetch_vld && !idu_ifu_instq_full && !flush.
  - Set lanes of fetch_lane_vld are compacted in lane order.
  - The k-th set lane is written to wr_ptr+k.
  - push = popcount(fetch_lane_vld).
  - A push with mask 0 writes nothing.
- Push while full: the fetch group is dropped silently. IFU is required to hold the group.
- Head outputs:
  - inst_vld[i] = (count > i).
  - Data for lane i comes from entry rd_ptr+i.
  - Data outputs are forced to 0 on invalid lanes.
- Pop: pop = number of leading ones of (dispatch_vld & inst_vld), counted from lane 0.
  - A non-prefix pattern is not an error; bits after the first zero are ignored.
  - Example: 2'b10 pops 0 entries.
- Update: count_next = count + push − pop.
  - Push and pop in the same cycle are legal.
  - Full is evaluated on the current count, not on the post-pop count.
- Flush = bru_flush | dispatcher_detect_exceptions_wfi.
  - Highest priority. rd_ptr, wr_ptr and count are cleared to 0.
  - Any push or pop in that same cycle is discarded.
- idu_ifu_instq_full = (DEPTH − count) < FETCH_W.
- instq_occupancy = count.

## Timing
- Reset: all outputs are 0; occupancy is 0 and full is 0 from the first edge with rst_n low. Reset applied mid-operation behaves as a flush.
- Outputs are combinational from registered state; there is no fetch→dispatch bypass.
- Push latency: data written at edge N is visible on inst_out after edge N.
- Full changes the cycle after the count crosses the threshold. With DEPTH=8 and W=2:
  - full=1 at count 7 or 8;
  - full=0 at count ≤6.
- Flush takes effect at the next edge. On the following cycle, inst_vld=0 and a push is accepted.

## Configuration
- INSTQ_PERF_CNT_EN defined:
  - Adds output instq_stall_cnt, 32 bits.
  - Increments each cycle where ifu_idu_fetch_vld && idu_ifu_instq_full.
  - Saturates at all-ones.
  - Cleared only by reset; not cleared by flush.
- INSTQ_PERF_CNT_EN undefined: the port and the counter are absent.

## Structure
- Shared package idu_pkg holds:
  - default DEPTH/FETCH_W/DISPATCH_W constants;
  - the popcount function;
  - the leading-ones function.
- Sub-module u_idu_instq_compact: takes fetch_lane_vld and produces, for each lane, a write offset and enable, plus the push count. It is purely combinational and instantiated once.

## Test plan
- Reset held 2 cycles with random inputs → all outputs 0, occupancy 0, full 0.
- Four pushes with mask 2'b11, data 0–7, dispatch_vld=00:
  - occupancy reaches 8 and full=1;
  - a fifth push of data 8,9 is dropped;
  - head shows 0,1.
- From 8 entries, dispatch 01 → occupancy 7, full stays 1. Then dispatch 11 → occupancy 5, full=0, head shows 3,4.
- Push mask 2'b10 with lane1 data 0xA5 into an empty queue → occupancy 1, inst_vld=01, inst_out[0]=0xA5. Dispatch_vld=10 → no pop.
- Flush with simultaneous push and dispatch (both flush sources, one at a time) → next cycle occupancy 0, inst_vld=00.
- Continuous push 2/pop 2 for 20 cycles across the pointer wrap → in-order PCs with no loss. With INSTQ_PERF_CNT_EN, instq_stall_cnt equals the number of full-stall cycles.
